// File: rtl/regfile_pkg.sv
// Shared register-file constants and writeback source indices.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int WB_SRC_ALU     = 0;
    localparam int WB_SRC_MULTDIV = 1;
    localparam int WB_SRC_LOAD    = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests by the pointer,
// take the lowest set bit, then map the offset back to a source index.
module rr_pick
    import regfile_pkg::*;
#(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [N-1:0]     rotated;
    logic [PTR_W-1:0] offset;
    logic [PTR_W:0]   sum;

    always_comb begin
        // NOTE: every output and temporary gets a default before the search, so no latch is inferred.
        grant   = '0;
        idx     = '0;
        any     = 1'b0;
        offset  = '0;
        rotated = N'({req, req} >> ptr);
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = PTR_W'(i);
                any    = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (PTR_W + 1)'(N)) begin
            sum = sum - (PTR_W + 1)'(N);
        end
        idx = PTR_W'(sum);
        if (any) begin
            grant = N'(1) << idx;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between
// writeback sources, with a registered write stage and in-flight visibility.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                      clock,
    input  logic                      ctrl_reset,
    input  logic                      wb_hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      ctrl_writeEnable,
    output logic [ADDR_W-1:0]         ctrl_writeReg,
    output logic [DATA_W-1:0]         data_writeReg,
    output logic                      pend_valid,
    output logic [ADDR_W-1:0]         pend_reg
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_any;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_reg;
    logic [DATA_W-1:0]  sel_data;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (grant_idx),
        .any   (pick_any)
    );

    // Grant depends only on valid, hold, pointer and reset; the data paths never reach req_ready.
    assign xfer      = pick_any & ~wb_hold & ~ctrl_reset;
    assign req_ready = xfer ? pick_grant : '0;
    assign sel_reg   = req_reg[grant_idx*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[grant_idx*DATA_W +: DATA_W];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            rr_ptr           <= '0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else if (xfer) begin
            rr_ptr           <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            ctrl_writeEnable <= (sel_reg != ADDR_W'(REG_ZERO));
            ctrl_writeReg    <= sel_reg;
            data_writeReg    <= sel_data;
        end else begin
            ctrl_writeEnable <= 1'b0;
        end
    end

    assign pend_valid = ctrl_writeEnable;
    assign pend_reg   = ctrl_writeReg;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 32×32 register file between several writeback sources (ALU, multiply/divide unit, load unit). Each source offers a destination register and result through a valid/ready handshake. The arbiter grants at most one source per cycle using round-robin, and drives the register-file write port from a registered stage one cycle later. It also exports the in-flight destination so hazard logic can see a write that has not yet reached the array.

## Interface
Parameters:
- NUM_REQ, 3, number of writeback sources (2–8); index 0 = ALU, 1 = multdiv, 2 = load
- DATA_W, 32, result width
- ADDR_W, 5, register index width

Ports:
- clock  in  1  rising-edge clock
- ctrl_reset  in  1  asynchronous, active-high reset
- wb_hold  in  1  when 1, no grants are issued this cycle
- req_valid  in  NUM_REQ  per-source request
- req_reg  in  NUM_REQ*ADDR_W  per-source destination; source i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  per-source result, packed the same way
- req_ready  out  NUM_REQ  one-hot grant; combinational
- ctrl_writeEnable  out  1  register-file write enable; registered
- ctrl_writeReg  out  ADDR_W  register-file write index; registered
- data_writeReg  out  DATA_W  register-file write data; registered
- pend_valid  out  1  a write is currently on the port
- pend_reg  out  ADDR_W  destination of that write

## Operation
- Handshake:
  - A transfer occurs on source i in a cycle where req_valid[i] && req_ready[i].
  - A source must hold valid, reg and data stable until that transfer.
  - Dropping valid before the transfer is illegal.
- Grant:
  - If wb_hold = 0 and any source is valid, exactly one source is granted: the first valid index found searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready is all-zero otherwise.
  - req_ready[i] is never asserted while req_valid[i] = 0.
- Pointer:
  - On a transfer from source g, rr_ptr ← (g+1) mod NUM_REQ.
  - With no transfer, rr_ptr is unchanged.
- Output stage:
  - On a transfer: ctrl_writeReg ← req_reg[g], data_writeReg ← req_data[g], and ctrl_writeEnable ← (req_reg[g] ≠ 0).
  - With no transfer: ctrl_writeEnable ← 0. ctrl_writeReg and data_writeReg hold their previous values.
- Register 0: a request to register 0 completes its handshake normally but produces no write enable. pend_valid stays 0 for it.
- pend_valid equals ctrl_writeEnable, and pend_reg equals ctrl_writeReg.
- Priority of events: reset > wb_hold > grant.
- The output stage never stalls, so throughput is one transfer per cycle.

## Timing
- Reset (asynchronous, immediate on assertion):
  - rr_ptr = 0
  - ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0
  - pend_valid = 0, pend_reg = 0
  - req_ready is forced to 0 while ctrl_reset = 1
- Reset mid-operation: any write in the output stage is discarded and not retried. Sources whose handshake did not complete keep valid asserted and are re-arbitrated after deassertion, starting from index 0.
- Latency: a transfer in cycle N appears on the write port in cycle N+1. The register file captures it at the end of cycle N+1.
- req_ready depends combinationally on req_valid, wb_hold, rr_ptr and ctrl_reset. It has no combinational path from req_reg or req_data.
- Fairness: a continuously valid source is granted within NUM_REQ cycles in which wb_hold = 0.
- Simultaneous wb_hold rise with pending requests: no grant that cycle. The previous transfer still drains to the port.

## Structure
- Shared package (regfile_pkg):
  - REG_ADDR_W = 5, REG_DATA_W = 32
  - REG_ZERO = 5'd0
  - source index constants WB_SRC_ALU = 0, WB_SRC_MULTDIV = 1, WB_SRC_LOAD = 2
- Sub-module rr_pick: parameter N.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational; rotate, priority-encode, un-rotate.
- Top level holds rr_ptr, the output register stage and the handshake gating.

## Test plan
- Reset: assert ctrl_reset mid-transfer with req_valid = 3'b111 → all outputs 0 immediately. After deassertion the first grant is source 0.
- Single source: source 1 valid, reg = 5'd7, data = 32'hDEADBEEF → req_ready = 3'b010 in the same cycle. Next cycle ctrl_writeEnable = 1, ctrl_writeReg = 7, data_writeReg = 32'hDEADBEEF.
- Round-robin: all three sources continuously valid for 6 cycles → grant order 0, 1, 2, 0, 1, 2, with six back-to-back writes of the matching data.
- Register zero: source 2 valid with reg = 0 → req_ready[2] = 1. Next cycle ctrl_writeEnable = 0 and pend_valid = 0. rr_ptr advances to 0.
- Hold: req_valid = 3'b011 with wb_hold = 1 for 3 cycles → req_ready = 0 and no writes. When wb_hold drops, source at rr_ptr is granted first, then the other.
- Fairness: source 0 requests every cycle while source 2 raises valid once → source 2 is granted within 3 cycles and its data reaches the port the following cycle.
